// File: rtl/pipelined_fp_multiplier.sv
// Sign/exponent/mantissa FP multiplier: unpack+multiply, normalize, round+pack in three register stages.
// Latency 3 at one result per cycle; a single enable freezes every stage while the output is blocked.
module pipelined_fp_multiplier #(
    parameter int EXP_W  = 8,
    parameter int MAN_W  = 7,
    parameter bit SAT_EN = 1'b0,
    localparam int W     = 1 + EXP_W + MAN_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    input  logic         in_rne,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_p,
    output logic [3:0]   out_flags
);
    localparam int SIG_W = MAN_W + 1;
    localparam int PRD_W = 2 * SIG_W;
    localparam int NRM_W = PRD_W - 1;
    localparam int EW    = EXP_W + 2;

    typedef logic signed [EW-1:0] exp_t;
    typedef enum logic [1:0] {K_NUM, K_ZERO, K_INF, K_NAN} kind_t;

    localparam exp_t BIAS    = exp_t'((2 ** (EXP_W - 1)) - 1);
    localparam exp_t EXP_TOP = exp_t'((2 ** EXP_W) - 1);
    localparam exp_t ONE     = exp_t'(1);

    logic             s1_vld_q, s1_vld_d, s1_sign_q, s1_sign_d, s1_rne_q, s1_rne_d;
    kind_t            s1_kind_q, s1_kind_d;
    exp_t             s1_exp_q, s1_exp_d;
    logic [PRD_W-1:0] s1_prod_q, s1_prod_d;
    logic             s2_vld_q, s2_vld_d, s2_sign_q, s2_sign_d, s2_rne_q, s2_rne_d;
    logic             s2_stk_q, s2_stk_d;
    kind_t            s2_kind_q, s2_kind_d;
    exp_t             s2_exp_q, s2_exp_d;
    logic [NRM_W-1:0] s2_man_q, s2_man_d;
    logic             out_vld_q, out_vld_d;
    logic [W-1:0]     out_p_q, out_p_d;
    logic [3:0]       out_flags_q, out_flags_d;

    logic en;
    assign en        = !out_vld_q || out_ready;
    assign in_ready  = en;
    assign out_valid = out_vld_q;
    assign out_p     = out_p_q;
    assign out_flags = out_flags_q;

    // Stage 1: unpack, classify, exponent sum, significand product
    logic [EXP_W-1:0] a_exp, b_exp, a_eff, b_eff;
    logic [MAN_W-1:0] a_man, b_man;
    logic             a_sub, b_sub, a_max, b_max, a_zero, b_zero;

    always_comb begin
        a_exp  = in_a[W-2 -: EXP_W];
        b_exp  = in_b[W-2 -: EXP_W];
        a_man  = in_a[MAN_W-1:0];
        b_man  = in_b[MAN_W-1:0];
        a_sub  = (a_exp == '0);
        b_sub  = (b_exp == '0);
        a_max  = &a_exp;
        b_max  = &b_exp;
        a_zero = a_sub && !(|a_man);
        b_zero = b_sub && !(|b_man);
        a_eff  = a_sub ? EXP_W'(1) : a_exp;
        b_eff  = b_sub ? EXP_W'(1) : b_exp;

        s1_vld_d  = s1_vld_q;
        s1_sign_d = s1_sign_q;
        s1_rne_d  = s1_rne_q;
        s1_kind_d = s1_kind_q;
        s1_exp_d  = s1_exp_q;
        s1_prod_d = s1_prod_q;
        if (en) begin
            s1_vld_d  = in_valid;
            s1_sign_d = in_a[W-1] ^ in_b[W-1];
            s1_rne_d  = in_rne;
            s1_exp_d  = exp_t'({2'b00, a_eff}) + exp_t'({2'b00, b_eff}) - BIAS;
            s1_prod_d = PRD_W'({!a_sub, a_man}) * PRD_W'({!b_sub, b_man});
            if ((a_max && |a_man) || (b_max && |b_man) || (a_max && b_zero) || (b_max && a_zero))
                s1_kind_d = K_NAN;
            else if (a_max || b_max)
                s1_kind_d = K_INF;
            else if (a_zero || b_zero)
                s1_kind_d = K_ZERO;
            else
                s1_kind_d = K_NUM;
        end
    end

    // Stage 2: left shift is capped so the exponent never drops below 1 (subnormal range)
    exp_t lzc, sh;

    always_comb begin
        lzc = exp_t'(NRM_W);
        for (int i = 0; i < NRM_W; i++)
            if (s1_prod_q[i]) lzc = exp_t'(NRM_W - 1 - i);
        sh = '0;
        if (s1_exp_q > ONE)
            sh = (lzc < s1_exp_q - ONE) ? lzc : s1_exp_q - ONE;

        s2_vld_d  = s2_vld_q;
        s2_sign_d = s2_sign_q;
        s2_rne_d  = s2_rne_q;
        s2_kind_d = s2_kind_q;
        s2_exp_d  = s2_exp_q;
        s2_man_d  = s2_man_q;
        s2_stk_d  = s2_stk_q;
        if (en) begin
            s2_vld_d  = s1_vld_q;
            s2_sign_d = s1_sign_q;
            s2_rne_d  = s1_rne_q;
            s2_kind_d = s1_kind_q;
            if (s1_prod_q[PRD_W-1]) begin
                s2_man_d = s1_prod_q[PRD_W-1:1];
                s2_stk_d = s1_prod_q[0];
                s2_exp_d = s1_exp_q + ONE;
            end else begin
                s2_man_d = s1_prod_q[NRM_W-1:0] << sh;
                s2_stk_d = 1'b0;
                s2_exp_d = s1_exp_q - sh;
            end
        end
    end

    // Stage 3: round, range check, special-case override
    logic [SIG_W-1:0] sig;
    logic [SIG_W:0]   sig_r;
    logic             grd, rnd, stk, inc;
    exp_t             exp_r;
    logic [W-1:0]     p_res;
    logic [3:0]       f_res;

    always_comb begin
        sig   = s2_man_q[NRM_W-1 -: SIG_W];
        grd   = s2_man_q[MAN_W-1];
        rnd   = s2_man_q[MAN_W-2];
        stk   = (|s2_man_q[MAN_W-3:0]) || s2_stk_q;
        inc   = s2_rne_q && grd && (rnd || stk || sig[0]);
        sig_r = {1'b0, sig} + (SIG_W+1)'(inc);
        exp_r = s2_exp_q;
        if (sig_r[SIG_W]) begin
            sig_r = sig_r >> 1;
            exp_r = s2_exp_q + ONE;
        end

        p_res = {s2_sign_q, exp_r[EXP_W-1:0], sig_r[MAN_W-1:0]};
        f_res = {3'b000, grd || rnd || stk};
        if (exp_r >= EXP_TOP) begin
            f_res = 4'b0101;
            p_res = SAT_EN ? {s2_sign_q, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}}
                           : {s2_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (exp_r < ONE || !sig_r[MAN_W]) begin
            f_res = {3'b001, (|sig) || grd || rnd || stk};
            p_res = {s2_sign_q, {(W-1){1'b0}}};
        end

        case (s2_kind_q)
            K_NAN: begin
                p_res = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
                f_res = 4'b1000;
            end
            K_INF: begin
                p_res = {s2_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                f_res = 4'b0000;
            end
            K_ZERO: begin
                p_res = {s2_sign_q, {(W-1){1'b0}}};
                f_res = 4'b0000;
            end
            default: ;
        endcase

        out_vld_d   = out_vld_q;
        out_p_d     = out_p_q;
        out_flags_d = out_flags_q;
        if (en) begin
            out_vld_d   = s2_vld_q;
            out_p_d     = p_res;
            out_flags_d = f_res;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld_q    <= 1'b0;
            s1_sign_q   <= 1'b0;
            s1_rne_q    <= 1'b0;
            s1_kind_q   <= K_NUM;
            s1_exp_q    <= '0;
            s1_prod_q   <= '0;
            s2_vld_q    <= 1'b0;
            s2_sign_q   <= 1'b0;
            s2_rne_q    <= 1'b0;
            s2_kind_q   <= K_NUM;
            s2_exp_q    <= '0;
            s2_man_q    <= '0;
            s2_stk_q    <= 1'b0;
            out_vld_q   <= 1'b0;
            out_p_q     <= '0;
            out_flags_q <= '0;
        end else begin
            s1_vld_q    <= s1_vld_d;
            s1_sign_q   <= s1_sign_d;
            s1_rne_q    <= s1_rne_d;
            s1_kind_q   <= s1_kind_d;
            s1_exp_q    <= s1_exp_d;
            s1_prod_q   <= s1_prod_d;
            s2_vld_q    <= s2_vld_d;
            s2_sign_q   <= s2_sign_d;
            s2_rne_q    <= s2_rne_d;
            s2_kind_q   <= s2_kind_d;
            s2_exp_q    <= s2_exp_d;
            s2_man_q    <= s2_man_d;
            s2_stk_q    <= s2_stk_d;
            out_vld_q   <= out_vld_d;
            out_p_q     <= out_p_d;
            out_flags_q <= out_flags_d;
        end
    end
endmodule
